// File: rtl/lpc_decoder.sv
// rtl/lpc_decoder.sv - passive LPC I/O and memory cycle sniffer
//
// Purpose:
//   Watches LFRAME#/LAD[3:0] on the LPC clock and follows target I/O and
//   memory read/write cycles. Each completed cycle updates the type,
//   address and data outputs and raises lpc_latch for LATCH_CYCLES
//   clocks. The block only listens and never drives the bus.
//
// Ports:
//   clock            in   LPC clock, all logic on the rising edge
//   reset            in   synchronous reset, active low
//   lpc_frame        in   LFRAME#, active low
//   lpc_ad[3:0]      in   LAD[3:0]
//   lpc_cyctype_dir  out  [3:2] type (00 I/O, 01 mem), [1] write, [0] raw
//   lpc_addr[31:0]   out  cycle address (I/O cycles zero-extended)
//   lpc_data[7:0]    out  cycle data byte
//   lpc_latch        out  high LATCH_CYCLES clocks after each completion
//   frame_error      out  one-clock pulse on a bad or timed-out SYNC
//   busy             out  high whenever the tracker is not idle

module lpc_decoder #(
  parameter int LATCH_CYCLES = 2,
  parameter int SYNC_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lpc_frame,
  input  logic [3:0]  lpc_ad,
  output logic [3:0]  lpc_cyctype_dir,
  output logic [31:0] lpc_addr,
  output logic [7:0]  lpc_data,
  output logic        lpc_latch,
  output logic        frame_error,
  output logic        busy
);

  localparam logic [2:0] LATCH_LOAD = 3'(LATCH_CYCLES);
  localparam logic [7:0] WAIT_LIMIT = 8'(SYNC_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    TAR1  = 3'd3,
    SYNC  = 3'd4,
    DATA  = 3'd5,
    TAR2  = 3'd6
  } state_t;

  state_t      state_q, state_d;

  // Shadow copies of the cycle being tracked; they reach the outputs only
  // on completion so an aborted cycle never disturbs the outputs.
  logic [3:0]  cyc_q, cyc_d;
  logic [31:0] addr_sh_q, addr_sh_d;
  logic [7:0]  data_sh_q, data_sh_d;

  // Shared nibble/turnaround counter; every state entry reloads it.
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  wait_q, wait_d;

  logic [3:0]  ct_out_q, ct_out_d;
  logic [31:0] addr_out_q, addr_out_d;
  logic [7:0]  data_out_q, data_out_d;
  logic [2:0]  latch_cnt_q, latch_cnt_d;
  logic        err_q, err_d;

  logic        complete;
  logic        is_write;
  logic [7:0]  wait_inc;

  assign is_write = cyc_q[1];
  assign wait_inc = wait_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    addr_sh_d  = addr_sh_q;
    data_sh_d  = data_sh_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    err_d      = 1'b0;
    complete   = 1'b0;

    if (!lpc_frame) begin
      // LFRAME# low overrides everything: only a target start code
      // (0000) begins a new cycle, anything else parks the tracker.
      state_d = (lpc_ad == 4'h0) ? START : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
        end

        START: begin
          cyc_d     = lpc_ad;
          addr_sh_d = 32'h0;
          data_sh_d = 8'h0;
          unique case (lpc_ad[3:2])
            2'b00: begin
              state_d = ADDR;
              cnt_d   = 4'd4;
            end
            2'b01: begin
              state_d = ADDR;
              cnt_d   = 4'd8;
            end
            default: state_d = IDLE;
          endcase
        end

        ADDR: begin
          // Address arrives MSB nibble first; the shadow was cleared at
          // START, so I/O cycles end up zero-extended automatically.
          addr_sh_d = {addr_sh_q[27:0], lpc_ad};
          cnt_d     = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            cnt_d   = 4'd0;
            state_d = is_write ? DATA : TAR1;
          end
        end

        DATA: begin
          if (cnt_q == 4'd0) begin
            data_sh_d[3:0] = lpc_ad;
            cnt_d          = 4'd1;
          end else begin
            data_sh_d[7:4] = lpc_ad;
            cnt_d          = 4'd0;
            if (is_write) begin
              state_d = TAR1;
            end else begin
              complete = 1'b1;
              state_d  = TAR2;
            end
          end
        end

        TAR1: begin
          if (cnt_q == 4'd0) begin
            cnt_d = 4'd1;
          end else begin
            cnt_d   = 4'd0;
            wait_d  = 8'd0;
            state_d = SYNC;
          end
        end

        SYNC: begin
          unique case (lpc_ad)
            4'h0: begin
              cnt_d = 4'd0;
              if (is_write) begin
                complete = 1'b1;
                state_d  = TAR2;
              end else begin
                state_d = DATA;
              end
            end
            4'h5, 4'h6: begin
              wait_d = wait_inc;
              if (wait_inc >= WAIT_LIMIT) begin
                err_d   = 1'b1;
                state_d = IDLE;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          endcase
        end

        TAR2: begin
          if (cnt_q == 4'd0) begin
            cnt_d = 4'd1;
          end else begin
            cnt_d   = 4'd0;
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // Output registers and the latch stretch counter run independently of
  // the tracker, so a new START or an abort cannot cut a strobe short.
  always_comb begin
    ct_out_d    = ct_out_q;
    addr_out_d  = addr_out_q;
    data_out_d  = data_out_q;
    latch_cnt_d = (latch_cnt_q != 3'd0) ? latch_cnt_q - 3'd1 : 3'd0;

    if (complete) begin
      ct_out_d    = cyc_q;
      addr_out_d  = addr_sh_q;
      // For reads the high data nibble is on the bus this very clock.
      data_out_d  = data_sh_d;
      latch_cnt_d = LATCH_LOAD;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      cyc_q       <= 4'h0;
      addr_sh_q   <= 32'h0;
      data_sh_q   <= 8'h0;
      cnt_q       <= 4'd0;
      wait_q      <= 8'd0;
      ct_out_q    <= 4'h0;
      addr_out_q  <= 32'h0;
      data_out_q  <= 8'h0;
      latch_cnt_q <= 3'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      ct_out_q    <= ct_out_d;
      addr_out_q  <= addr_out_d;
      data_out_q  <= data_out_d;
      latch_cnt_q <= latch_cnt_d;
      err_q       <= err_d;
    end
  end

  assign lpc_cyctype_dir = ct_out_q;
  assign lpc_addr        = addr_out_q;
  assign lpc_data        = data_out_q;
  assign lpc_latch       = (latch_cnt_q != 3'd0);
  assign frame_error     = err_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_lpc_decoder.sv
// tb/tb_lpc_decoder.sv - directed self-checking bench for lpc_decoder

module tb_lpc_decoder;

  logic        clk;
  logic        reset;
  logic        lpc_frame;
  logic [3:0]  lpc_ad;
  logic [3:0]  lpc_cyctype_dir;
  logic [31:0] lpc_addr;
  logic [7:0]  lpc_data;
  logic        lpc_latch;
  logic        frame_error;
  logic        busy;

  lpc_decoder #(
    .LATCH_CYCLES(2),
    .SYNC_TIMEOUT(255)
  ) dut (
    .clock           (clk),
    .reset           (reset),
    .lpc_frame       (lpc_frame),
    .lpc_ad          (lpc_ad),
    .lpc_cyctype_dir (lpc_cyctype_dir),
    .lpc_addr        (lpc_addr),
    .lpc_data        (lpc_data),
    .lpc_latch       (lpc_latch),
    .frame_error     (frame_error),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int lat_rise = 0;
  int lat_hi   = 0;
  int err_cnt  = 0;
  int overlap  = 0;
  logic        lat_prev = 1'b0;
  logic [3:0]  snap_ct  = 4'h0;
  logic [31:0] snap_addr = 32'h0;
  logic [7:0]  snap_data = 8'h0;

  int r0, h0, e0;
  logic [3:0] fq[$];

  always @(negedge clk) begin
    if (lpc_latch) lat_hi <= lat_hi + 1;
    if (lpc_latch && !lat_prev) begin
      lat_rise  <= lat_rise + 1;
      snap_ct   <= lpc_cyctype_dir;
      snap_addr <= lpc_addr;
      snap_data <= lpc_data;
    end
    lat_prev <= lpc_latch;
    if (frame_error) err_cnt <= err_cnt + 1;
    if (frame_error && lpc_latch) overlap <= overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nib(input logic f, input logic [3:0] a);
    @(posedge clk);
    #1;
    lpc_frame = f;
    lpc_ad    = a;
  endtask

  task automatic send();
    nib(1'b0, 4'h0);
    foreach (fq[i]) nib(1'b1, fq[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) nib(1'b1, 4'hF);
  endtask

  task automatic base();
    r0 = lat_rise;
    h0 = lat_hi;
    e0 = err_cnt;
  endtask

  initial begin
    reset     = 1'b0;
    lpc_frame = 1'b1;
    lpc_ad    = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ct",    lpc_cyctype_dir, 4'h0);
    check("rst_addr",  lpc_addr, 32'h0);
    check("rst_data",  lpc_data, 8'h0);
    check("rst_latch", lpc_latch, 1'b0);
    check("rst_err",   frame_error, 1'b0);
    check("rst_busy",  busy, 1'b0);
    reset = 1'b1;
    idle(2);

    // I/O write 0x0080 = 0x5A with latch timing
    base();
    fq = {4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'hA, 4'h5, 4'hF, 4'hF};
    send();
    nib(1'b1, 4'h0);
    check("iow_latch_pre", lpc_latch, 1'b0);
    nib(1'b1, 4'hF);
    check("iow_latch_1", lpc_latch, 1'b1);
    check("iow_busy", busy, 1'b1);
    nib(1'b1, 4'hF);
    check("iow_latch_2", lpc_latch, 1'b1);
    nib(1'b1, 4'hF);
    check("iow_latch_3", lpc_latch, 1'b0);
    idle(3);
    check("iow_rises", lat_rise - r0, 1);
    check("iow_width", lat_hi - h0, 2);
    check("iow_err",   err_cnt - e0, 0);
    check("iow_ct",    snap_ct, 4'h2);
    check("iow_addr",  snap_addr, 32'h0000_0080);
    check("iow_data",  snap_data, 8'h5A);

    // Memory read 0xFFFFFFF0 with three long waits
    base();
    fq = {4'h4, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0,
          4'hF, 4'hF, 4'h6, 4'h6, 4'h6, 4'h0, 4'hC, 4'h3, 4'hF, 4'hF};
    send();
    idle(3);
    check("mrd_rises", lat_rise - r0, 1);
    check("mrd_width", lat_hi - h0, 2);
    check("mrd_err",   err_cnt - e0, 0);
    check("mrd_ct",    snap_ct, 4'h4);
    check("mrd_addr",  snap_addr, 32'hFFFF_FFF0);
    check("mrd_data",  snap_data, 8'h3C);

    // Abort after two address nibbles, then I/O read 0x0060 = 0x11
    base();
    fq = {4'h0, 4'h0, 4'h0};
    send();
    nib(1'b0, 4'h0);
    nib(1'b0, 4'h0);
    check("abt_ct",    lpc_cyctype_dir, 4'h4);
    check("abt_addr",  lpc_addr, 32'hFFFF_FFF0);
    check("abt_data",  lpc_data, 8'h3C);
    check("abt_latch", lpc_latch, 1'b0);
    check("abt_busy",  busy, 1'b1);
    fq = {4'h0, 4'h0, 4'h0, 4'h6, 4'h0, 4'hF, 4'hF, 4'h0, 4'h1, 4'h1, 4'hF, 4'hF};
    foreach (fq[i]) nib(1'b1, fq[i]);
    idle(3);
    check("abt_rises", lat_rise - r0, 1);
    check("abt_err",   err_cnt - e0, 0);
    check("ior_ct",    snap_ct, 4'h0);
    check("ior_addr",  snap_addr, 32'h0000_0060);
    check("ior_data",  snap_data, 8'h11);

    // Illegal SYNC 1010 on an I/O read
    base();
    fq = {4'h0, 4'h0, 4'h0, 4'h6, 4'h0, 4'hF, 4'hF};
    send();
    nib(1'b1, 4'hA);
    nib(1'b1, 4'hF);
    check("sye_err",   frame_error, 1'b1);
    check("sye_busy",  busy, 1'b0);
    check("sye_latch", lpc_latch, 1'b0);
    idle(3);
    check("sye_errs",  err_cnt - e0, 1);
    check("sye_rises", lat_rise - r0, 0);

    // 256 consecutive short waits hit the 255 timeout
    base();
    fq = {4'h0, 4'h0, 4'h0, 4'h6, 4'h0, 4'hF, 4'hF};
    send();
    for (int i = 0; i < 256; i++) begin
      nib(1'b1, 4'h5);
      if (i == 254) check("tmo_busy_before", busy, 1'b1);
    end
    check("tmo_busy_after", busy, 1'b0);
    idle(3);
    check("tmo_errs",  err_cnt - e0, 1);
    check("tmo_rises", lat_rise - r0, 0);

    // DMA cycle type, then a non-target start code
    base();
    nib(1'b0, 4'h0);
    nib(1'b1, 4'h8);
    check("dma_busy_start", busy, 1'b1);
    nib(1'b1, 4'hF);
    check("dma_busy_idle", busy, 1'b0);
    nib(1'b0, 4'hD);
    nib(1'b1, 4'hF);
    check("nts_busy", busy, 1'b0);
    idle(3);
    check("dma_rises", lat_rise - r0, 0);
    check("dma_errs",  err_cnt - e0, 0);

    // Reset pulse in the data phase of a memory write
    base();
    fq = {4'h6, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
    send();
    nib(1'b1, 4'hA);
    reset = 1'b0;
    nib(1'b1, 4'hF);
    reset = 1'b1;
    check("mrst_ct",    lpc_cyctype_dir, 4'h0);
    check("mrst_addr",  lpc_addr, 32'h0);
    check("mrst_data",  lpc_data, 8'h0);
    check("mrst_busy",  busy, 1'b0);
    nib(1'b1, 4'hF);
    nib(1'b1, 4'h0);
    idle(4);
    check("mrst_rises", lat_rise - r0, 0);
    check("mrst_errs",  err_cnt - e0, 0);

    // I/O write 0x1234 = 0xC7 after the reset
    base();
    fq = {4'h2, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'hC, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF};
    send();
    idle(3);
    check("iow2_rises", lat_rise - r0, 1);
    check("iow2_width", lat_hi - h0, 2);
    check("iow2_ct",    snap_ct, 4'h2);
    check("iow2_addr",  snap_addr, 32'h0000_1234);
    check("iow2_data",  snap_data, 8'hC7);

    check("err_latch_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lpc_decoder.md
Name: lpc_decoder

Overview:
Front-end sniffer stage: samples LFRAME#/LAD[3:0] on the LPC clock, tracks each target I/O or memory cycle (read or write) and presents cycle type/direction, address and data with a stretched latch strobe. Its outputs drive the LPC-frame-to-RAM writer directly: lpc_cyctype_dir, lpc_addr, lpc_data, lpc_latch. Passive only; never drives the bus.

Parameters:
LATCH_CYCLES, 2, clocks lpc_latch stays high (the downstream writer may run at half LPC clock); legal 1..7
SYNC_TIMEOUT, 255, max consecutive SYNC wait nibbles (0101/0110) before abort; 8-bit counter

Ports:
clock  in  1  LPC clock; all logic on posedge
reset  in  1  synchronous, active-low reset
lpc_frame  in  1  LFRAME#, active low
lpc_ad  in  4  LAD[3:0]
lpc_cyctype_dir  out  4  [3:2] type (00 I/O, 01 mem), [1] dir (1 write), [0] as sampled
lpc_addr  out  32  address; I/O cycles zero-extend 16 bits
lpc_data  out  8  data byte
lpc_latch  out  1  high LATCH_CYCLES clocks per completed cycle; outputs stable while high and until next latch
frame_error  out  1  one-clock pulse on SYNC error/illegal SYNC/timeout
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (reset==0 at posedge): state IDLE, all outputs 0, shadow regs and counters 0. Reset mid-frame: no latch, no error pulse; the rest of the frame is ignored until a new START.
- States: IDLE, START, ADDR, TAR1, SYNC, DATA, TAR2.
- Global rule, highest priority: lpc_frame==0 in any state -> START if lpc_ad==0000, else IDLE (non-target start codes ignored). Abort of an in-progress cycle: no latch, no error, outputs unchanged.
- START: stay while lpc_frame==0 and lpc_ad==0000. First lpc_frame==1 sample = CYCTYPE nibble: capture into shadow; type 00 -> ADDR, nibble count 4; type 01 -> ADDR, count 8; 10/11 (DMA/reserved) -> IDLE.
- ADDR: one nibble per clock, MSB nibble first, shifted into shadow address. After the last nibble: write -> DATA; read -> TAR1.
- DATA: 2 nibbles, low nibble first. Write -> TAR1 after the second nibble. Read -> completion after the second nibble, then TAR2.
- TAR1: 2 clocks, LAD ignored, then SYNC.
- SYNC: 0000 -> write: completion, then TAR2; read: DATA. 0101/0110 -> stay, wait counter +1; on reaching SYNC_TIMEOUT -> frame_error, IDLE. 1010 or any other value -> frame_error, IDLE. Wait counter clears on SYNC entry.
- TAR2: 2 clocks, then IDLE. A new START may follow immediately.
- Completion: at the posedge sampling the final nibble (write: SYNC 0000; read: data high nibble), shadow regs transfer to lpc_cyctype_dir/lpc_addr/lpc_data. lpc_latch rises on that same edge (registered; visible the clock after the sample) and stays high exactly LATCH_CYCLES clocks. If lpc_frame==0 on the completing sample, abort wins: no update, no latch.
- Latch stretch counter runs independently of the FSM: abort or START during the stretch does not shorten it or change outputs. The minimum frame length exceeds 7 clocks, so completions never overlap.
- I/O: lpc_addr[31:16]=0. Memory: full 32 bits.
- busy low only in IDLE. frame_error is never asserted alongside lpc_latch for the same cycle.

Test Plan:
- I/O write 0x0080=0x5A: frame 0000, LAD 2,0,0,8,0,A,5,F,F,0,F,F -> one latch, 2 clocks, cyctype_dir=0x2, addr=0x00000080, data=0x5A, frame_error=0.
- Memory read 0xFFFFFFF0, 3 long waits: CYCTYPE 4, addr F,F,F,F,F,F,F,0, TAR F,F, SYNC 6,6,6,0, data C,3 -> latch after the data high nibble, cyctype_dir=0x4, addr=0xFFFFFFF0, data=0x3C.
- Abort: lpc_frame low after the 2nd I/O address nibble with LAD=0000, then a full I/O read 0x0060=0x11 -> exactly one latch, addr=0x00000060, data=0x11; previous outputs untouched until then.
- SYNC 1010 on an I/O read; separately 256 consecutive SYNC 0101 with SYNC_TIMEOUT=255 -> one frame_error pulse each, no latch, busy drops the clock after.
- DMA cyctype 1000, then non-zero start code 1101 -> no latch, no error, busy low after one clock.
- Reset low for one clock mid-data of a memory write -> outputs 0, no latch; the following valid I/O write latches normally.
